// File: rtl/pcpu_pkg.sv
// Shared definitions for the pcpu pipeline: opcodes, register indices, run state
// and the decode predicates used by hazard, forwarding and flag logic.
package pcpu_pkg;

   typedef enum logic [4:0] {
      OP_NOP   = 5'b00000, OP_HALT = 5'b00001, OP_LOAD = 5'b00010, OP_STORE = 5'b00011,
      OP_SLL   = 5'b00100, OP_SLA  = 5'b00101, OP_SRA  = 5'b00110, OP_SRL   = 5'b00111,
      OP_ADD   = 5'b01000, OP_ADDI = 5'b01001, OP_SUB  = 5'b01010, OP_SUBI  = 5'b01011,
      OP_CMP   = 5'b01100, OP_AND  = 5'b01101, OP_OR   = 5'b01110, OP_XOR   = 5'b01111,
      OP_LDIH  = 5'b10000, OP_ADDC = 5'b10001, OP_SUBC = 5'b10010,
      OP_JUMP  = 5'b11000, OP_JMPR = 5'b11001, OP_BZ   = 5'b11010, OP_BNZ   = 5'b11011,
      OP_BN    = 5'b11100, OP_BNN  = 5'b11101, OP_BC   = 5'b11110, OP_BNC   = 5'b11111
   } opcode_e;

   typedef enum logic [2:0] {GR0, GR1, GR2, GR3, GR4, GR5, GR6, GR7} gr_idx_e;

   typedef enum logic {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_e;

   localparam logic [15:0] NOP_INSTR = 16'h0000;

   // Visible window of a 640x480 frame inside the sync counters
   localparam logic [9:0] H_DISP_START = 10'd144;
   localparam logic [9:0] H_DISP_END   = 10'd784;
   localparam logic [9:0] V_DISP_START = 10'd35;
   localparam logic [9:0] V_DISP_END   = 10'd515;

   function automatic logic writes_r1(input logic [4:0] op);
      case (op)
         OP_LOAD, OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC,
         OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SLA, OP_SRA, OP_SRL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic reads_r1(input logic [4:0] op);
      case (op)
         OP_LDIH, OP_ADDI, OP_SUBI, OP_STORE, OP_JMPR,
         OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic reads_r3(input logic [4:0] op);
      case (op)
         OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic reads_r2(input logic [4:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_SLL, OP_SLA, OP_SRA, OP_SRL: return 1'b1;
         default: return reads_r3(op);
      endcase
   endfunction

   function automatic logic sets_cf(input logic [4:0] op);
      case (op)
         OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic sets_zn(input logic [4:0] op);
      case (op)
         OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SLA, OP_SRA, OP_SRL: return 1'b1;
         default: return sets_cf(op);
      endcase
   endfunction

endpackage

// File: rtl/pcpu_alu.sv
// Combinational ALU for the EX stage; cf is carry-out for adds and borrow for subtracts.
module pcpu_alu
   import pcpu_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cf_in,
   output logic [15:0] result,
   output logic        zf,
   output logic        nf,
   output logic        cf
);

   logic [16:0] wide;

   always_comb begin
      wide = {1'b0, a} + {1'b0, b};
      case (op)
         OP_ADDC:                 wide = {1'b0, a} + {1'b0, b} + {16'h0000, cf_in};
         OP_SUB, OP_SUBI, OP_CMP: wide = {1'b0, a} - {1'b0, b};
         OP_SUBC:                 wide = {1'b0, a} - {1'b0, b} - {16'h0000, cf_in};
         OP_AND:                  wide = {1'b0, a & b};
         OP_OR:                   wide = {1'b0, a | b};
         OP_XOR:                  wide = {1'b0, a ^ b};
         OP_SLL, OP_SLA:          wide = {1'b0, a << b[3:0]};
         OP_SRL:                  wide = {1'b0, a >> b[3:0]};
         OP_SRA:                  wide = {1'b0, $signed(a) >>> b[3:0]};
         default:                 ;
      endcase
      result = wide[15:0];
      cf     = wide[16];
      zf     = (wide[15:0] == 16'h0000);
      nf     = wide[15];
   end

endmodule

// File: rtl/pcpu_core.sv
// 5-stage 16-bit pipelined CPU stepped by a synchronised mclk strobe,
// with a free-running VGA sync generator showing flags and run state.
module pcpu_core
   import pcpu_pkg::*;
#(
   parameter int H_TOTAL = 800,
   parameter int H_SYNC  = 96,
   parameter int V_TOTAL = 525,
   parameter int V_SYNC  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mclk,
   input  logic        enable,
   input  logic        start,
   input  logic [15:0] i_datain,
   input  logic [15:0] d_datain,
   output logic        d_we,
   output logic [7:0]  d_addr,
   output logic [7:0]  pc,
   output logic [15:0] d_dataout,
   output logic [2:0]  red,
   output logic [2:0]  green,
   output logic [1:0]  blue,
   output logic        hs,
   output logic        vs
);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SW   = 10'(H_SYNC);
   localparam logic [9:0] V_SW   = 10'(V_SYNC);

   state_e      state_q, state_d;
   logic [2:0]  mclk_sync_q, mclk_sync_d;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] id_ir_q, id_ir_d, ex_ir_q, ex_ir_d, mem_ir_q, mem_ir_d, wb_ir_q, wb_ir_d;
   logic [15:0] reg_A_q, reg_A_d, reg_B_q, reg_B_d, smdr_q, smdr_d, smdr1_q, smdr1_d;
   logic [15:0] reg_C_q, reg_C_d, reg_C1_q, reg_C1_d;
   logic        zf_q, zf_d, nf_q, nf_d, cf_q, cf_d;
   logic [15:0] gr_q [0:7];
   logic [15:0] gr_d [0:7];
   logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;

   logic [15:0] id_ir, ex_ir, mem_ir, wb_ir, reg_A, reg_B, reg_C, reg_C1, smdr, ALU0;
   logic [15:0] gr [0:7];
   logic        zf, nf, cf, beq;

   logic        mclk_step, load_use, alu_zf, alu_nf, alu_cf, displaying;
   logic [4:0]  id_op, ex_op, mem_op, wb_op;
   logic [2:0]  id_r1, id_r2, id_r3;
   logic [7:0]  id_imm8;
   logic [15:0] src1, src2, src3, a_val, b_val, mem_val;

   assign id_op   = id_ir_q[15:11];
   assign ex_op   = ex_ir_q[15:11];
   assign mem_op  = mem_ir_q[15:11];
   assign wb_op   = wb_ir_q[15:11];
   assign id_r1   = id_ir_q[10:8];
   assign id_r2   = id_ir_q[6:4];
   assign id_r3   = id_ir_q[2:0];
   assign id_imm8 = id_ir_q[7:0];

   assign mclk_step = enable && mclk_sync_q[1] && !mclk_sync_q[2];
   assign mem_val   = (mem_op == OP_LOAD) ? d_datain : reg_C_q;

   pcpu_alu u_alu (
      .op     (ex_op),
      .a      (reg_A_q),
      .b      (reg_B_q),
      .cf_in  (cf_q),
      .result (ALU0),
      .zf     (alu_zf),
      .nf     (alu_nf),
      .cf     (alu_cf)
   );

   // Youngest in-flight producer wins; WB must forward because it writes on the same edge
   function automatic logic [15:0] fwd(input logic [2:0] idx, input logic [15:0] rf_val);
      if (writes_r1(ex_op) && ex_ir_q[10:8] == idx)   return ALU0;
      if (writes_r1(mem_op) && mem_ir_q[10:8] == idx) return mem_val;
      if (writes_r1(wb_op) && wb_ir_q[10:8] == idx)   return reg_C1_q;
      return rf_val;
   endfunction

   always_comb begin
      src1 = fwd(id_r1, gr_q[id_r1]);
      src2 = fwd(id_r2, gr_q[id_r2]);
      src3 = fwd(id_r3, gr_q[id_r3]);
      case (id_op)
         OP_LDIH, OP_ADDI, OP_SUBI, OP_JMPR,
         OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: a_val = src1;
         OP_JUMP:                                    a_val = 16'h0000;
         default:                                    a_val = src2;
      endcase
      case (id_op)
         OP_LDIH:                                     b_val = {id_imm8, 8'h00};
         OP_ADDI, OP_SUBI, OP_JUMP, OP_JMPR,
         OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: b_val = {8'h00, id_imm8};
         OP_LOAD, OP_STORE, OP_SLL, OP_SLA,
         OP_SRA, OP_SRL:                              b_val = {12'h000, id_ir_q[3:0]};
         default:                                     b_val = src3;
      endcase
      load_use = (ex_op == OP_LOAD) &&
                 ((reads_r1(id_op) && id_r1 == ex_ir_q[10:8]) ||
                  (reads_r2(id_op) && id_r2 == ex_ir_q[10:8]) ||
                  (reads_r3(id_op) && id_r3 == ex_ir_q[10:8]));
      case (ex_op)
         OP_JUMP, OP_JMPR: beq = 1'b1;
         OP_BZ:            beq = zf_q;
         OP_BNZ:           beq = !zf_q;
         OP_BN:            beq = nf_q;
         OP_BNN:           beq = !nf_q;
         OP_BC:            beq = cf_q;
         OP_BNC:           beq = !cf_q;
         default:          beq = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mclk_sync_d = {mclk_sync_q[1:0], mclk};
      pc_d        = pc_q;
      id_ir_d     = id_ir_q;
      ex_ir_d     = ex_ir_q;
      mem_ir_d    = mem_ir_q;
      wb_ir_d     = wb_ir_q;
      reg_A_d     = reg_A_q;
      reg_B_d     = reg_B_q;
      smdr_d      = smdr_q;
      smdr1_d     = smdr1_q;
      reg_C_d     = reg_C_q;
      reg_C1_d    = reg_C1_q;
      zf_d        = zf_q;
      nf_d        = nf_q;
      cf_d        = cf_q;
      gr_d        = gr_q;
      case (state_q)
         ST_IDLE: if (start && enable) state_d = ST_EXEC;
         ST_EXEC: if (mclk_step && mem_op == OP_HALT) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (state_q == ST_EXEC && mclk_step) begin
         if (beq) begin
            pc_d    = ALU0[7:0];
            id_ir_d = NOP_INSTR;
            ex_ir_d = NOP_INSTR;
         end else if (load_use) begin
            ex_ir_d = NOP_INSTR;
         end else begin
            pc_d    = pc_q + 8'd1;
            id_ir_d = i_datain;
            ex_ir_d = id_ir_q;
         end
         reg_A_d  = a_val;
         reg_B_d  = b_val;
         smdr_d   = src1;
         reg_C_d  = ALU0;
         smdr1_d  = smdr_q;
         mem_ir_d = ex_ir_q;
         if (sets_zn(ex_op)) begin
            zf_d = alu_zf;
            nf_d = alu_nf;
         end
         if (sets_cf(ex_op)) cf_d = alu_cf;
         reg_C1_d = mem_val;
         wb_ir_d  = mem_ir_q;
         if (writes_r1(wb_op)) gr_d[wb_ir_q[10:8]] = reg_C1_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mclk_sync_q <= '0;
         pc_q        <= '0;
         id_ir_q     <= NOP_INSTR;
         ex_ir_q     <= NOP_INSTR;
         mem_ir_q    <= NOP_INSTR;
         wb_ir_q     <= NOP_INSTR;
         reg_A_q     <= '0;
         reg_B_q     <= '0;
         smdr_q      <= '0;
         smdr1_q     <= '0;
         reg_C_q     <= '0;
         reg_C1_q    <= '0;
         zf_q        <= 1'b0;
         nf_q        <= 1'b0;
         cf_q        <= 1'b0;
         for (int i = 0; i < 8; i++) gr_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         mclk_sync_q <= mclk_sync_d;
         pc_q        <= pc_d;
         id_ir_q     <= id_ir_d;
         ex_ir_q     <= ex_ir_d;
         mem_ir_q    <= mem_ir_d;
         wb_ir_q     <= wb_ir_d;
         reg_A_q     <= reg_A_d;
         reg_B_q     <= reg_B_d;
         smdr_q      <= smdr_d;
         smdr1_q     <= smdr1_d;
         reg_C_q     <= reg_C_d;
         reg_C1_q    <= reg_C1_d;
         zf_q        <= zf_d;
         nf_q        <= nf_d;
         cf_q        <= cf_d;
         for (int i = 0; i < 8; i++) gr_q[i] <= gr_d[i];
      end
   end

   always_comb begin
      h_cnt_d = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign displaying = (h_cnt_q >= H_DISP_START) && (h_cnt_q < H_DISP_END) &&
                       (v_cnt_q >= V_DISP_START) && (v_cnt_q < V_DISP_END);
   assign hs    = (h_cnt_q >= H_SW);
   assign vs    = (v_cnt_q >= V_SW);
   assign red   = displaying ? {zf_q, nf_q, cf_q} : 3'b000;
   assign green = displaying ? {state_q == ST_EXEC, 2'b00} : 3'b000;
   assign blue  = 2'b00;

   assign d_we      = (mem_op == OP_STORE);
   assign d_addr    = reg_C_q[7:0];
   assign d_dataout = smdr1_q;
   assign pc        = pc_q;

   assign id_ir  = id_ir_q;
   assign ex_ir  = ex_ir_q;
   assign mem_ir = mem_ir_q;
   assign wb_ir  = wb_ir_q;
   assign reg_A  = reg_A_q;
   assign reg_B  = reg_B_q;
   assign reg_C  = reg_C_q;
   assign reg_C1 = reg_C1_q;
   assign smdr   = smdr_q;
   assign zf     = zf_q;
   assign nf     = nf_q;
   assign cf     = cf_q;
   assign gr     = gr_q;

endmodule

// File: tb/tb_pcpu_core.sv
// Directed bench for pcpu_core: runs a small program from a ROM model and
// checks registers, flags, memory strobes, branching, halt and reset.
module tb_pcpu_core;

   logic        clk = 1'b0;
   logic        reset, mclk, enable, start;
   logic [15:0] i_datain, d_datain;
   logic        d_we;
   logic [7:0]  d_addr, pc;
   logic [15:0] d_dataout;
   logic [2:0]  red, green;
   logic [1:0]  blue;
   logic        hs, vs;

   logic [15:0] rom  [0:255];
   logic [15:0] dmem [0:255];
   int          total = 0;
   int          bad   = 0;

   pcpu_core dut (
      .clk       (clk),
      .reset     (reset),
      .mclk      (mclk),
      .enable    (enable),
      .start     (start),
      .i_datain  (i_datain),
      .d_datain  (d_datain),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .pc        (pc),
      .d_dataout (d_dataout),
      .red       (red),
      .green     (green),
      .blue      (blue),
      .hs        (hs),
      .vs        (vs)
   );

   // 100 MHz-style clock; ROM and RAM answer combinationally, RAM writes on clk
   always #5 clk = ~clk;

   assign i_datain = rom[pc];
   assign d_datain = dmem[d_addr];

   always @(posedge clk) begin
      if (d_we) dmem[d_addr] <= d_dataout;
   end

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, actual, expected);
      end
   endtask

   // One mclk pulse, long enough for the synchroniser to see a single rising edge
   task automatic applyStimulus();
      @(negedge clk);
      mclk = 1'b1;
      repeat (4) @(negedge clk);
      mclk = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulseStart();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rom[i]  = 16'h0000;
         dmem[i] = 16'h0000;
      end
      dmem[1]   = 16'h00C3;
      rom[8'h00] = 16'h1101;  // LOAD  gr1, gr0, 1
      rom[8'h01] = 16'h81FC;  // LDIH  gr1, 0xFC
      rom[8'h02] = 16'h49FF;  // ADDI  gr1, 0xFF
      rom[8'h03] = 16'h82FC;  // LDIH  gr2, 0xFC
      rom[8'h04] = 16'h4312;  // ADD   gr3, gr1, gr2
      rom[8'h05] = 16'h6111;  // CMP   gr1, gr1
      rom[8'h06] = 16'hD0BC;  // BZ    gr0, 0xBC
      rom[8'h07] = 16'h4C11;  // ADDI  gr4, 0x11 (squashed)
      rom[8'h08] = 16'h4D22;  // ADDI  gr5, 0x22 (squashed)
      rom[8'hBC] = 16'h5222;  // SUB   gr2, gr2, gr2
      rom[8'hBD] = 16'h4A10;  // ADDI  gr2, 0x10
      rom[8'hBE] = 16'h5111;  // SUB   gr1, gr1, gr1
      rom[8'hBF] = 16'h8112;  // LDIH  gr1, 0x12
      rom[8'hC0] = 16'h4934;  // ADDI  gr1, 0x34
      rom[8'hC1] = 16'h1923;  // STORE gr1, gr2, 3
      rom[8'hC2] = 16'h7E12;  // XOR   gr6, gr1, gr2
      rom[8'hC3] = 16'h3734;  // SRA   gr7, gr3, 4
      rom[8'hC4] = 16'h3D34;  // SRL   gr5, gr3, 4
      rom[8'hC5] = 16'h2414;  // SLL   gr4, gr1, 4
      rom[8'hC6] = 16'h0800;  // HALT

      reset  = 1'b1;
      mclk   = 1'b0;
      enable = 1'b1;
      start  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_pc", {8'h00, pc}, 16'h0000);
      checkOutput("rst_id_ir", dut.id_ir, 16'h0000);
      checkOutput("rst_wb_ir", dut.wb_ir, 16'h0000);
      checkOutput("rst_d_we", {15'h0, d_we}, 16'h0000);
      checkOutput("rst_hs", {15'h0, hs}, 16'h0000);
      reset = 1'b0;

      // Idle: a step must not advance the pc
      applyStimulus();
      checkOutput("idle_pc", {8'h00, pc}, 16'h0000);
      repeat (100) @(negedge clk);
      checkOutput("hs_high", {15'h0, hs}, 16'h0001);
      checkOutput("vs_low", {15'h0, vs}, 16'h0000);

      pulseStart();
      enable = 1'b0;
      applyStimulus();
      checkOutput("frozen_pc", {8'h00, pc}, 16'h0000);
      enable = 1'b1;

      repeat (3) applyStimulus();
      checkOutput("load_d_addr", {8'h00, d_addr}, 16'h0001);
      checkOutput("stall_pc", {8'h00, pc}, 16'h0002);
      checkOutput("stall_id_ir", dut.id_ir, 16'h81FC);
      checkOutput("stall_bubble", dut.ex_ir, 16'h0000);

      repeat (2) applyStimulus();
      checkOutput("load_gr1", dut.gr[1], 16'h00C3);
      repeat (2) applyStimulus();
      checkOutput("ldih_gr1", dut.gr[1], 16'hFCC3);
      applyStimulus();
      checkOutput("addi_gr1", dut.gr[1], 16'hFDC2);
      checkOutput("add_cf", {15'h0, dut.cf}, 16'h0001);
      checkOutput("add_nf", {15'h0, dut.nf}, 16'h0001);
      checkOutput("add_zf", {15'h0, dut.zf}, 16'h0000);

      applyStimulus();
      checkOutput("ldih_gr2", dut.gr[2], 16'hFC00);
      checkOutput("cmp_zf", {15'h0, dut.zf}, 16'h0001);
      checkOutput("bz_beq", {15'h0, dut.beq}, 16'h0001);
      checkOutput("bz_target", dut.ALU0, 16'h00BC);

      applyStimulus();
      checkOutput("branch_pc", {8'h00, pc}, 16'h00BC);
      checkOutput("add_gr3", dut.gr[3], 16'hF9C2);
      checkOutput("squash_id", dut.id_ir, 16'h0000);
      checkOutput("squash_ex", dut.ex_ir, 16'h0000);

      repeat (4) applyStimulus();
      checkOutput("squash_gr4", dut.gr[4], 16'h0000);
      checkOutput("squash_gr5", dut.gr[5], 16'h0000);

      repeat (4) applyStimulus();
      checkOutput("store_we", {15'h0, d_we}, 16'h0001);
      checkOutput("store_addr", {8'h00, d_addr}, 16'h0013);
      checkOutput("store_data", d_dataout, 16'h1234);

      applyStimulus();
      checkOutput("store_we_off", {15'h0, d_we}, 16'h0000);
      checkOutput("store_mem", dmem[8'h13], 16'h1234);
      checkOutput("addi_gr1b", dut.gr[1], 16'h1234);

      repeat (5) applyStimulus();
      checkOutput("xor_gr6", dut.gr[6], 16'h1224);
      checkOutput("sra_gr7", dut.gr[7], 16'hFF9C);
      checkOutput("srl_gr5", dut.gr[5], 16'h0F9C);
      checkOutput("sll_gr4", dut.gr[4], 16'h2340);
      checkOutput("halt_pc", {8'h00, pc}, 16'h00CA);

      repeat (2) applyStimulus();
      checkOutput("halted_pc", {8'h00, pc}, 16'h00CA);
      checkOutput("halted_wb_ir", dut.wb_ir, 16'h0800);

      pulseStart();
      repeat (2) applyStimulus();
      checkOutput("restart_pc", {8'h00, pc}, 16'h00CC);

      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rst_pc", {8'h00, pc}, 16'h0000);
      checkOutput("async_rst_gr4", dut.gr[4], 16'h0000);
      checkOutput("async_rst_gr7", dut.gr[7], 16'h0000);
      checkOutput("async_rst_wb_ir", dut.wb_ir, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus();
      checkOutput("post_rst_idle_pc", {8'h00, pc}, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pcpu_core.md
Name: pcpu_core

Overview:
- 5-stage pipelined 16-bit CPU: IF, ID, EX, MEM, WB.
- Register file: 8 x 16-bit. Harvard memory interface: 8-bit instruction and data addresses, instruction/data memories external.
- Also drives a minimal VGA sync/status output so board flags/state are visible.
- Sits between external instruction ROM, data RAM and the VGA connector.

Parameters:
- H_TOTAL, 800, clk ticks per VGA line.
- H_SYNC, 96, hs low width.
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, vs low width (lines).

Ports:
- clk  in  1  sole clock; all flops rise on it.
- reset  in  1  asynchronous, active-high; clears all state.
- mclk  in  1  step strobe, sampled in clk domain (2-flop synchroniser). Pipeline advances once per detected rising edge of mclk.
- enable  in  1  1 = steps allowed; 0 = everything frozen.
- start  in  1  idle->exec request.
- i_datain  in  16  instruction at address pc (combinational ROM).
- d_datain  in  16  data read at d_addr (combinational RAM).
- d_we  out  1  store strobe.
- d_addr  out  8  data address.
- pc  out  8  fetch address.
- d_dataout  out  16  store data.
- red/green/blue  out  3/3/2  status colour.
- hs/vs  out  1  VGA syncs, active-low.

Behaviour:
Instruction fields:
- op[15:11], r1[10:8], r2[6:4], r3[2:0], val2[7:4], val3[3:0]; imm8 = {val2,val3}, zero-extended.

Opcodes:
- NOP 00000; HALT 00001; LOAD 00010; STORE 00011; LDIH 10000.
- ADD 01000; ADDI 01001; ADDC 10001; SUB 01010; SUBI 01011; SUBC 10010; CMP 01100.
- AND 01101; OR 01110; XOR 01111; SLL 00100; SLA 00101; SRA 00110; SRL 00111.
- JUMP 11000; JMPR 11001; BZ 11010; BNZ 11011; BN 11100; BNN 11101; BC 11110; BNC 11111.

Semantics:
- LOAD: gr1 <= mem[gr2+val3].
- STORE: mem[gr2+val3] <= gr1.
- LDIH: gr1 <= gr1 + {imm8,8'h00}.
- ADD / SUB / ADDC / SUBC: gr1 <= gr2 op gr3 (op ±cf for the carry forms).
- ADDI / SUBI: gr1 <= gr1 ± imm8.
- AND / OR / XOR: gr1 <= gr2 op gr3.
- Shifts: gr1 <= gr2 shifted by val3. SLA = SLL; SRA sign-fills.
- CMP: flags from gr2-gr3, no write.
- JUMP: pc <= imm8.
- JMPR / taken branch: pc <= (gr1+imm8)[7:0].

Flags:
- zf, nf update on every ALU op except LOAD, STORE, LDIH, jumps, branches, NOP, HALT.
- cf updates on ADD*, SUB*, CMP only (carry-out / borrow).
- All flags latched at end of EX.

State machine:
- idle->exec when start=1 and enable=1.
- exec->idle when HALT reaches WB.
- In idle: pc and pipeline hold.

Reset (async):
- pc=0, state=idle, gr[0..7]=0, flags=0.
- id_ir/ex_ir/mem_ir/wb_ir=NOP; reg_A/reg_B/reg_C/reg_C1/smdr=0.
- d_we=0.

Pipeline step (exec, enable=1, mclk rising):
- IF: id_ir <= i_datain; pc <= pc+1.
- ID: read reg_A/reg_B/smdr with forwarding. Priority: EX result (ALU0), then MEM (reg_C, or d_datain if LOAD), then WB (reg_C1).
- EX: ALU0 -> reg_C.
- MEM: d_addr = reg_C[7:0]; d_dataout = smdr1; d_we = (mem_ir==STORE). reg_C1 <= LOAD ? d_datain : reg_C.
- WB: gr[r1] <= reg_C1 for writing ops; gr0 is writable.
- Load-use: when id_ir reads the r1 of a LOAD in EX, insert one bubble (ex_ir <= NOP, pc and id_ir held).

Branches:
- Resolved in EX: beq = jump, or branch condition true on current flags.
- When beq=1: pc <= ALU0[7:0]; id_ir and ex_ir <= NOP next step. Two-slot penalty, no delay slot.

Internal names used by bench probes (must exist): id_ir, ex_ir, mem_ir, wb_ir, reg_A, reg_B, ALU0, reg_C, reg_C1, smdr, gr[0:7], zf, nf, cf, beq.

VGA:
- Free-running h/v counters on clk.
- Colour while displaying: red = {zf,nf,cf}; green = {state,2'b00}; blue = 0.

Decomposition:
- Shared package: opcode constants, gr index constants, idle/exec state constants.
- One sub-module natural: pcpu_alu (combinational; op, A, B, cf_in -> result, zf, nf, cf).

Test Plan:
1. reset, enable=1, start pulse; LOAD gr1,gr0,1 with d_datain=0x00C3 -> d_addr=0x01 in MEM; gr1=0x00C3 after WB.
2. LDIH gr1,0xFC, then ADDI gr1,0xFF (back-to-back, forwarded) -> gr1=0xFCC3, then 0xFDC2.
3. LDIH gr2,0xFC from 0 -> gr2=0xFC00; then ADD gr3,gr1,gr2 -> gr3=0xF9C2, cf=1, nf=1, zf=0.
4. CMP gr1,gr1,gr1 then BZ gr0,0xBC -> zf=1; beq=1 in EX; pc=0xBC next step; the two following instructions become NOP and change no register.
5. STORE gr1,gr2,3 with gr2=0x0010, gr1=0x1234 -> d_we=1 one step, d_addr=0x13, d_dataout=0x1234.
6. HALT -> returns to idle after WB; pc frozen. Reset asserted mid-exec -> all state cleared immediately.
